// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: word length, parity mode and stop bits are
// fixed at elaboration; samples each bit at its centre using a clock divider.
module uart_rx_cfg #(
  parameter int p_CLK_DIV   = 10,
  parameter int p_WORD_LEN  = 8,
  parameter int p_PARITY    = 0,
  parameter int p_STOP_BITS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  output logic [p_WORD_LEN-1:0] o_data,
  output logic                  o_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_active
);

  if (p_CLK_DIV < 4 || p_WORD_LEN < 5 || p_WORD_LEN > 9 ||
      p_PARITY < 0 || p_PARITY > 2 ||
      (p_STOP_BITS != 1 && p_STOP_BITS != 2)) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter value");
  end

  localparam int   CW  = $clog2(p_CLK_DIV);
  localparam int   HLF = p_CLK_DIV / 2;
  localparam logic PEN = (p_PARITY != 0);
  localparam logic ODD = (p_PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t                state;
  logic                  rx_m, rx_s;
  logic [CW-1:0]         cnt;
  logic [3:0]            idx;
  logic [p_WORD_LEN-1:0] shreg;
  logic                  par_bit;
  logic                  ferr;
  logic                  zero;
  logic                  tick_half;
  logic                  tick;
  logic                  par_err;

  assign tick_half = (cnt == CW'(HLF - 1));
  assign tick      = (cnt == CW'(p_CLK_DIV - 1));
  // odd: xor of data and parity must be 1; even: must be 0
  assign par_err   = PEN & (^shreg ^ par_bit ^ ODD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      ferr         <= 1'b0;
      zero         <= 1'b0;
      o_data       <= '0;
      o_ready      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_active     <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      cnt     <= cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state    <= START;
            o_active <= 1'b1;
          end
        end
        START: begin
          if (tick_half) begin
            cnt <= '0;
            if (rx_s) begin
              state    <= IDLE;
              o_active <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
              zero  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[p_WORD_LEN-1:1]};
            zero  <= zero & ~rx_s;
            idx   <= idx + 4'd1;
            if (idx == 4'(p_WORD_LEN - 1)) begin
              idx   <= '0;
              ferr  <= 1'b0;
              state <= PEN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bit <= rx_s;
            zero    <= zero & ~rx_s;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            idx <= idx + 4'd1;
            if (idx == 4'(p_STOP_BITS - 1)) begin
              o_ready      <= 1'b1;
              o_data       <= shreg;
              o_parity_err <= par_err;
              o_frame_err  <= ferr | ~rx_s;
              o_break      <= zero & ~rx_s;
              o_active     <= ~rx_s;
              state        <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              ferr <= ferr | ~rx_s;
              zero <= zero & ~rx_s;
            end
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state    <= IDLE;
            o_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
